// File: rtl/rv32i_psram_lsu_pkg.sv
// Shared types for the rv32i PSRAM load/store unit: access sizes, FSM states
// and the alignment rule used to reject misaligned requests.
package rv32i_psram_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  function automatic logic lsu_misaligned(lsu_size_e size, logic [1:0] addr_lo);
    return ((size == LSU_H) && addr_lo[0]) || ((size == LSU_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/rv32i_psram_lsu_if.sv
// 16-bit PSRAM controller bus as seen by the LSU (master) and controller (slave).
interface rv32i_psram_lsu_if #(
  parameter int unsigned ADDR_W = 23
);
  logic [ADDR_W-2:0] ps_addr;
  logic [15:0]       ps_data_in;
  logic              ps_write_en;
  logic              ps_read_en;
  logic              ps_write_high_byte;
  logic              ps_write_low_byte;
  logic              ps_busy;
  logic              ps_read_avail;
  logic [15:0]       ps_data_out;

  modport master (
    output ps_addr, ps_data_in, ps_write_en, ps_read_en,
           ps_write_high_byte, ps_write_low_byte,
    input  ps_busy, ps_read_avail, ps_data_out
  );

  modport slave (
    input  ps_addr, ps_data_in, ps_write_en, ps_read_en,
           ps_write_high_byte, ps_write_low_byte,
    output ps_busy, ps_read_avail, ps_data_out
  );
endinterface

// File: rtl/rv32i_psram_lsu_load_align.sv
// Load data alignment: selects the addressed byte/half/word from the captured
// PSRAM beats and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import rv32i_psram_lsu_pkg::*;
(
  input  logic [15:0] beat0,
  input  logic [15:0] beat1,
  input  logic        addr0,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);
  logic [7:0] lane_b;

  always_comb begin
    lane_b = addr0 ? beat0[15:8] : beat0[7:0];
    rdata  = '0;
    case (size)
      LSU_B:   rdata = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      LSU_H:   rdata = {{16{~is_unsigned & beat0[15]}}, beat0};
      LSU_W:   rdata = {beat1, beat0};
      default: rdata = '0;
    endcase
  end
endmodule

// File: rtl/rv32i_psram_lsu.sv
// rv32i MA-stage load/store unit onto a 16-bit PSRAM controller.
// Optional one-entry store buffer: define RV32I_LSU_STORE_BUFFER_EN.
module rv32i_psram_lsu
  import rv32i_psram_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 23
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  lsu_size_e   req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misaligned,
  rv32i_psram_lsu_if.master ps
);
  localparam logic [ADDR_W-2:0] WADDR_ONE = {{(ADDR_W-2){1'b0}}, 1'b1};

  lsu_state_e        state_q, state_d;
  lsu_size_e         size_q;
  logic              we_q, uns_q, addr0_q, mis_q, beat_q;
  logic [15:0]       wdata_hi_q, beat0_q, beat1_q, ps_data_q;
  logic [ADDR_W-2:0] ps_addr_q;
  logic              ps_hi_q, ps_lo_q;
  logic              mis_now, accept, issue, beat_done, next_beat, stall_raw;
  logic [31:0]       align_rdata;
  logic              unused_addr;

  assign mis_now     = lsu_misaligned(req_size, req_addr[1:0]);
  assign unused_addr = ^req_addr[31:ADDR_W];

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    issue     = 1'b0;
    beat_done = 1'b0;
    next_beat = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = mis_now ? RESP : ISSUE;
      end
      ISSUE: if (!ps.ps_busy) begin
        issue   = 1'b1;
        state_d = GUARD;
      end
      GUARD: state_d = WAIT;
      WAIT: begin
        beat_done = we_q ? !ps.ps_busy : ps.ps_read_avail;
        if (beat_done) begin
          next_beat = (size_q == LSU_W) && !beat_q;
          state_d   = next_beat ? ISSUE : RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef RV32I_LSU_STORE_BUFFER_EN
  // buf_q marks the in-flight access as a posted store: the core was already
  // acknowledged, so only a new request is held back while it drains.
  logic buf_q, ack_q;

  always_comb begin
    stall_raw = 1'b0;
    if (state_q == IDLE)
      stall_raw = req_valid && !(req_we && !mis_now);
    else if (buf_q)
      stall_raw = req_valid;
    else
      stall_raw = (state_q != RESP);
  end

  assign rsp_valid = ack_q || ((state_q == RESP) && !mis_q && !buf_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= accept && req_we && !mis_now;
      if (accept)
        buf_q <= req_we && !mis_now;
      else if (state_q == RESP)
        buf_q <= 1'b0;
    end
  end
`else
  assign stall_raw = (state_q == IDLE) ? req_valid : (state_q != RESP);
  assign rsp_valid = (state_q == RESP) && !mis_q;
`endif

  assign stall      = reset_n && stall_raw;
  assign misaligned = (state_q == RESP) && mis_q;
  assign rsp_rdata  = ((state_q == RESP) && !mis_q && !we_q) ? align_rdata : '0;

  assign ps.ps_read_en         = issue && !we_q;
  assign ps.ps_write_en        = issue && we_q;
  assign ps.ps_addr            = ps_addr_q;
  assign ps.ps_data_in         = ps_data_q;
  assign ps.ps_write_high_byte = ps_hi_q;
  assign ps.ps_write_low_byte  = ps_lo_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      size_q     <= LSU_B;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      addr0_q    <= 1'b0;
      mis_q      <= 1'b0;
      beat_q     <= 1'b0;
      wdata_hi_q <= '0;
      beat0_q    <= '0;
      beat1_q    <= '0;
      ps_data_q  <= '0;
      ps_addr_q  <= '0;
      ps_hi_q    <= 1'b0;
      ps_lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req_we;
        size_q     <= req_size;
        uns_q      <= req_unsigned;
        addr0_q    <= req_addr[0];
        mis_q      <= mis_now;
        beat_q     <= 1'b0;
        wdata_hi_q <= req_wdata[31:16];
        if (!mis_now) begin
          ps_addr_q <= req_addr[ADDR_W-1:1];
          if (req_size == LSU_B) begin
            ps_data_q <= {2{req_wdata[7:0]}};
            ps_hi_q   <= req_addr[0];
            ps_lo_q   <= ~req_addr[0];
          end else begin
            ps_data_q <= req_wdata[15:0];
            ps_hi_q   <= 1'b1;
            ps_lo_q   <= 1'b1;
          end
        end
      end
      if (beat_done && !we_q) begin
        if (beat_q) beat1_q <= ps.ps_data_out;
        else        beat0_q <= ps.ps_data_out;
      end
      if (next_beat) begin
        beat_q    <= 1'b1;
        ps_addr_q <= ps_addr_q + WADDR_ONE;
        ps_data_q <= wdata_hi_q;
      end
    end
  end

  lsu_load_align u_align (
    .beat0       (beat0_q),
    .beat1       (beat1_q),
    .addr0       (addr0_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (align_rdata)
  );
endmodule

// File: tb/tb_rv32i_psram_lsu.sv
// Self-checking bench for rv32i_psram_lsu: byte-level memory model, PSRAM
// controller model, response scoreboard and directed access sequences.
module tb_rv32i_psram_lsu;
  import rv32i_psram_lsu_pkg::*;

  localparam int unsigned ADDR_W = 23;
  localparam int RLAT = 2;
  localparam int WLAT = 3;
  localparam bit [31:0] AMASK = (32'h1 << ADDR_W) - 32'h1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_we, req_unsigned;
  lsu_size_e   req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, misaligned;
  logic [31:0] rsp_rdata;

  rv32i_psram_lsu_if #(.ADDR_W(ADDR_W)) psif ();

  rv32i_psram_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .misaligned   (misaligned),
    .ps           (psif.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- PSRAM controller model ----------------
  typedef struct packed {
    bit              we;
    bit [ADDR_W-2:0] addr;
    bit [15:0]       data;
    bit              hi;
    bit              lo;
  } cmd_t;

  cmd_t      cmd_log[$];
  bit [15:0] pmem [0:4095];
  int        busy_cnt = 0;
  bit        rd_pend = 1'b0, avail_r = 1'b0, force_busy = 1'b0;
  bit [15:0] dout_r = '0;
  bit [11:0] rd_idx = '0;

  assign psif.ps_busy       = force_busy || (busy_cnt != 0);
  assign psif.ps_read_avail = avail_r;
  assign psif.ps_data_out   = dout_r;

  always @(posedge clk) begin
    cmd_t      c;
    bit [11:0] ix;
    avail_r <= 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1 && rd_pend) begin
        avail_r <= 1'b1;
        dout_r  <= pmem[rd_idx];
        rd_pend <= 1'b0;
      end
    end
    c.we = psif.ps_write_en; c.addr = psif.ps_addr; c.data = psif.ps_data_in;
    c.hi = psif.ps_write_high_byte; c.lo = psif.ps_write_low_byte;
    ix = psif.ps_addr[11:0];
    if (psif.ps_write_en) begin
      cmd_log.push_back(c);
      pmem[ix] <= {c.hi ? c.data[15:8] : pmem[ix][15:8], c.lo ? c.data[7:0] : pmem[ix][7:0]};
      busy_cnt <= WLAT;
    end
    if (psif.ps_read_en) begin
      cmd_log.push_back(c);
      rd_pend  <= 1'b1;
      rd_idx   <= ix;
      busy_cnt <= RLAT;
    end
  end

  // ---------------- byte-level reference memory ----------------
  bit [7:0] ref_mem [0:8191];

  function automatic bit [12:0] ref_ix(input bit [31:0] a);
    bit [31:0] k;
    k = a & AMASK;
    return k[12:0];
  endfunction

  function automatic int nbytes(input lsu_size_e sz);
    return (sz == LSU_B) ? 1 : (sz == LSU_H) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input lsu_size_e sz, input bit [31:0] a);
    return (sz == LSU_H && a[0]) || (sz == LSU_W && a[1:0] != 2'b00);
  endfunction

  function automatic bit [31:0] model_load(input lsu_size_e sz, input bit uns, input bit [31:0] a);
    bit [31:0] v;
    int nb;
    v  = '0;
    nb = nbytes(sz);
    for (int i = 0; i < nb; i++) v |= 32'(ref_mem[ref_ix(a + 32'(i))]) << (8 * i);
    if (!uns && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
    return v;
  endfunction

  task automatic model_store(input lsu_size_e sz, input bit [31:0] a, input bit [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[ref_ix(a + 32'(i))] = wd[8*i +: 8];
  endtask

  // ---------------- response scoreboard ----------------
  typedef struct packed {
    bit        mis;
    bit        chk;
    bit [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   prev_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (psif.ps_write_en || psif.ps_read_en) begin
        check("cmd_excl", 32'(psif.ps_write_en & psif.ps_read_en), 32'd0);
        check("cmd_width", 32'(prev_en), 32'd0);
      end
      prev_en <= psif.ps_write_en || psif.ps_read_en;
      if (rsp_valid || misaligned) begin
        check("rsp_excl", 32'(rsp_valid & misaligned), 32'd0);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_mis", 32'(misaligned), 32'(e.mis));
          if (e.chk) check("rsp_rdata", rsp_rdata, e.data);
        end
      end
    end else begin
      prev_en <= 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit last_mis;

  task automatic push_exp(input bit we, input lsu_size_e sz, input bit uns, input bit [31:0] a, input bit [31:0] wd);
    exp_t e;
    e.mis  = is_mis(sz, a);
    e.chk  = e.mis || !we;
    e.data = (e.mis || we) ? 32'd0 : model_load(sz, uns, a);
    exp_q.push_back(e);
    if (we && !e.mis) model_store(sz, a, wd);
  endtask

  // Starts and ends on a falling edge; lat = cycles from request to stall release.
  task automatic do_access(input bit we, input lsu_size_e sz, input bit uns, input bit [31:0] a,
                           input bit [31:0] wd, output int lat, output bit [31:0] rd);
    push_exp(we, sz, uns, a, wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    lat = 0;
    #1;
    while (stall && lat < 200) begin
      @(negedge clk); #1;
      lat++;
    end
    if (stall) check("access_timeout", 32'd1, 32'd0);
    rd       = rsp_rdata;
    last_mis = misaligned;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({stall, rsp_valid, misaligned, psif.ps_write_en, psif.ps_read_en,
                              psif.ps_write_high_byte, psif.ps_write_low_byte}), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_ps_addr"}, 32'(psif.ps_addr), 32'd0);
    check({tag, "_ps_data"}, 32'(psif.ps_data_in), 32'd0);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic check_cmd(input string tag, input int idx, input bit we, input bit [31:0] addr,
                           input bit [15:0] data, input bit hi, input bit lo);
    if (idx >= cmd_log.size()) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_we"},    32'(cmd_log[idx].we), 32'(we));
      check({tag, "_addr"},  32'(cmd_log[idx].addr), addr);
      if (we) check({tag, "_data"}, 32'(cmd_log[idx].data), 32'(data));
      check({tag, "_lanes"}, 32'({cmd_log[idx].hi, cmd_log[idx].lo}), 32'({hi, lo}));
    end
  endtask

  localparam int LAT_LD = 3 + RLAT;
`ifdef RV32I_LSU_STORE_BUFFER_EN
  localparam int LAT_ST = 0;
`else
  localparam int LAT_ST = 3 + WLAT;
`endif

  initial begin
    int        lat, cyc;
    bit [31:0] rd;
    bit        stall_low, cmd_seen;

    reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = LSU_W;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #3;
    check_zero("reset");
    @(negedge clk); @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);

    // Word store and load back
    cmd_log.delete();
    do_access(1'b1, LSU_W, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd);
    settle();
    check("sw_ncmd", 32'(cmd_log.size()), 32'd2);
    check_cmd("sw_b0", 0, 1'b1, 32'h80, 16'hBEEF, 1'b1, 1'b1);
    check_cmd("sw_b1", 1, 1'b1, 32'h81, 16'hDEAD, 1'b1, 1'b1);
    check("model_lw100", model_load(LSU_W, 1'b0, 32'h100), 32'hDEADBEEF);
    do_access(1'b0, LSU_W, 1'b0, 32'h100, 32'h0, lat, rd);
    check("lw_100", rd, 32'hDEADBEEF);

    // Byte store on the high lane, signed and unsigned byte loads
    cmd_log.delete();
    do_access(1'b1, LSU_B, 1'b0, 32'h203, 32'h00000080, lat, rd);
    check("sb_lat", 32'(lat), 32'(LAT_ST));
    settle();
    check_cmd("sb_203", 0, 1'b1, 32'h101, 16'h8080, 1'b1, 1'b0);
    check("model_lb203", model_load(LSU_B, 1'b0, 32'h203), 32'hFFFFFF80);
    do_access(1'b0, LSU_B, 1'b0, 32'h203, 32'h0, lat, rd);
    check("lb_lat", 32'(lat), 32'(LAT_LD));
    check("lb_203", rd, 32'hFFFFFF80);
    do_access(1'b0, LSU_B, 1'b1, 32'h203, 32'h0, lat, rd);
    check("lbu_203", rd, 32'h00000080);

    // Misaligned requests
    cmd_log.delete();
    do_access(1'b0, LSU_H, 1'b0, 32'h101, 32'h0, lat, rd);
    check("lh_mis_lat", 32'(lat), 32'd1);
    check("lh_mis_pulse", 32'(last_mis), 32'd1);
    do_access(1'b1, LSU_W, 1'b0, 32'h102, 32'h11223344, lat, rd);
    check("sw_mis_lat", 32'(lat), 32'd1);
    check("sw_mis_pulse", 32'(last_mis), 32'd1);
    settle();
    check("mis_ncmd", 32'(cmd_log.size()), 32'd0);

    // Controller busy while the LSU waits to issue
    cmd_log.delete();
    force_busy = 1'b1;
    push_exp(1'b0, LSU_H, 1'b0, 32'h200, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_size = LSU_H; req_unsigned = 1'b0; req_addr = 32'h200;
    stall_low = 1'b0; cmd_seen = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (!stall) stall_low = 1'b1;
      if (psif.ps_read_en || psif.ps_write_en) cmd_seen = 1'b1;
    end
    check("busy_stall_held", 32'(stall_low), 32'd0);
    check("busy_no_cmd", 32'(cmd_seen) | 32'(cmd_log.size()), 32'd0);
    @(negedge clk);
    force_busy = 1'b0;
    #1;
    check("busy_issue", 32'(psif.ps_read_en), 32'd1);
    cyc = 0;
    while (stall && cyc < 100) begin @(negedge clk); #1; cyc++; end
    check("busy_done", 32'(stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;

    // Half and byte patterns, low lane, word assembled from pieces
    cmd_log.delete();
    do_access(1'b1, LSU_H, 1'b0, 32'h204, 32'h00008001, lat, rd);
    check("sh_lat", 32'(lat), 32'(LAT_ST));
    do_access(1'b0, LSU_H, 1'b0, 32'h204, 32'h0, lat, rd);
    check("lh_lat", 32'(lat), 32'(LAT_LD));
    check("lh_204", rd, 32'hFFFF8001);
    do_access(1'b0, LSU_H, 1'b1, 32'h204, 32'h0, lat, rd);
    check("lhu_204", rd, 32'h00008001);
    cmd_log.delete();
    do_access(1'b1, LSU_B, 1'b0, 32'h206, 32'hAAAA007F, lat, rd);
    settle();
    check_cmd("sb_206", 0, 1'b1, 32'h103, 16'h7F7F, 1'b0, 1'b1);
    do_access(1'b0, LSU_B, 1'b0, 32'h206, 32'h0, lat, rd);
    check("lb_206", rd, 32'h0000007F);
    do_access(1'b0, LSU_W, 1'b0, 32'h204, 32'h0, lat, rd);
    check("lw_204", rd, 32'h007F8001);

    // Reset in the middle of beat 1 of a word load
    settle();
    cmd_log.delete();
    req_valid = 1'b1; req_we = 1'b0; req_size = LSU_W; req_unsigned = 1'b0; req_addr = 32'h100;
    cyc = 0;
    while (cmd_log.size() < 2 && cyc < 100) begin @(negedge clk); cyc++; end
    check("rst_beat1_issued", 32'(cmd_log.size()), 32'd2);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    settle();
    check("midreset_silent", 32'(exp_q.size()), 32'd0);
    do_access(1'b0, LSU_W, 1'b0, 32'h100, 32'h0, lat, rd);
    check("lw_after_reset", rd, 32'hDEADBEEF);

    // Byte-address bits above ADDR_W are not forwarded
    cmd_log.delete();
    do_access(1'b1, LSU_W, 1'b0, 32'h00800100, 32'h12345678, lat, rd);
    settle();
    check_cmd("alias_b0", 0, 1'b1, 32'h80, 16'h5678, 1'b1, 1'b1);
    do_access(1'b0, LSU_W, 1'b0, 32'h100, 32'h0, lat, rd);
    check("lw_alias", rd, 32'h12345678);

`ifdef RV32I_LSU_STORE_BUFFER_EN
    // Posted store followed at once by a load of the same word
    do_access(1'b1, LSU_W, 1'b0, 32'h300, 32'hCAFEF00D, lat, rd);
    check("sbuf_sw_nostall", 32'(lat), 32'd0);
    do_access(1'b0, LSU_W, 1'b0, 32'h300, 32'h0, lat, rd);
    check("sbuf_lw_stalled", 32'(lat > LAT_LD), 32'd1);
    check("sbuf_lw_data", rd, 32'hCAFEF00D);
`endif

    settle();
    check("all_rsp_seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 required 0");
    $fatal(1, "timeout");
  end
endmodule
